// File: rtl/bloco_operacional_pkg.sv
// Shared definitions for the 6-instruction processor datapath and its controller.
// Holds the ALU operation and write-back source encodings plus the sizing
// constants that the datapath and the controller agree on.
package bloco_operacional_pkg;

  localparam int DATA_W   = 8;
  localparam int RF_DEPTH = 16;
  localparam int RF_AW    = 4;
  localparam int DM_DEPTH = 256;
  localparam int DM_AW    = 8;

  // ALU operation select {alu_s1, alu_s0}
  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_ZERO = 2'b11
  } alu_op_t;

  // Register-file write-back source select {RF_s1, RF_s0}; 2'b11 writes zero
  typedef enum logic [1:0] {
    SEL_ALU   = 2'b00,
    SEL_MEM   = 2'b01,
    SEL_CONST = 2'b10
  } rf_sel_t;

endpackage

// File: rtl/bloco_operacional_banco_registradores.sv
// banco_registradores: RF_DEPTH x DATA_W register file.
// Ports:
//   clk, reset        clock; asynchronous active-high clear of every register
//   i_w_wr/i_w_addr/i_w_data   single write port, captured on the rising edge
//   i_rp_rd/i_rp_addr/o_rp_data read port P, combinational, 0 when disabled
//   i_rq_rd/i_rq_addr/o_rq_data read port Q, combinational, 0 when disabled
// There is no write-to-read bypass: a write lands at the edge, so a read of
// the same register in the write cycle still returns the old value.
module banco_registradores #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 16,
  parameter int RF_AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_w_wr,
  input  logic [RF_AW-1:0]  i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_rp_rd,
  input  logic [RF_AW-1:0]  i_rp_addr,
  input  logic              i_rq_rd,
  input  logic [RF_AW-1:0]  i_rq_addr,
  output logic [DATA_W-1:0] o_rp_data,
  output logic [DATA_W-1:0] o_rq_data
);

  logic [DATA_W-1:0] r_regs [RF_DEPTH];

  // Asynchronous clear: a write scheduled on the edge where reset is already
  // high is dropped because the reset branch wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_w_wr) begin
      r_regs[i_w_addr] <= i_w_data;
    end
  end

  always_comb begin
    o_rp_data = i_rp_rd ? r_regs[i_rp_addr] : '0;
    o_rq_data = i_rq_rd ? r_regs[i_rq_addr] : '0;
  end

endmodule

// File: rtl/bloco_operacional.sv
// bloco_operacional: datapath of the 6-instruction processor.
// Register file (sub-module), 8-bit ALU, 3-source write-back mux and a
// 256 x 8 data memory, all driven cycle by cycle by the controller.
// Ports:
//   clk, reset                 clock; async active-high reset (clears registers)
//   D_addr, D_rd, D_wr         data memory address / read enable / write enable
//                              (write data is the Rp read value)
//   RF_W_data                  immediate constant for MOVC
//   RF_s1, RF_s0               write-back source select
//   RF_W_addr, RF_W_wr         register write address / enable
//   RF_Rp_addr, RF_Rp_rd       read port P address / enable
//   RF_Rq_addr, RF_Rq_rd       read port Q address / enable
//   alu_s1, alu_s0             ALU operation select
//   RF_Rp_zero                 Rp enabled and Rp value is zero (JMPZ test)
//   Rp_data, Rq_data           read port values
// Everything between the read addresses and the register D-input is
// combinational; no output is registered.
module bloco_operacional #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        D_addr,
  input  logic              D_rd,
  input  logic              D_wr,
  input  logic [DATA_W-1:0] RF_W_data,
  input  logic              RF_s0,
  input  logic              RF_s1,
  input  logic [3:0]        RF_W_addr,
  input  logic [3:0]        RF_Rp_addr,
  input  logic [3:0]        RF_Rq_addr,
  input  logic              RF_W_wr,
  input  logic              RF_Rp_rd,
  input  logic              RF_Rq_rd,
  input  logic              alu_s0,
  input  logic              alu_s1,
  output logic              RF_Rp_zero,
  output logic [DATA_W-1:0] Rp_data,
  output logic [DATA_W-1:0] Rq_data
);

  import bloco_operacional_pkg::*;

  logic [DATA_W-1:0] r_dmem [DM_DEPTH];

  logic [DATA_W-1:0] w_rp_data;
  logic [DATA_W-1:0] w_rq_data;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_wb_data;
  alu_op_t           w_alu_op;
  rf_sel_t           w_wb_sel;

  banco_registradores #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH),
    .RF_AW    (4)
  ) u_banco (
    .clk       (clk),
    .reset     (reset),
    .i_w_wr    (RF_W_wr),
    .i_w_addr  (RF_W_addr),
    .i_w_data  (w_wb_data),
    .i_rp_rd   (RF_Rp_rd),
    .i_rp_addr (RF_Rp_addr),
    .i_rq_rd   (RF_Rq_rd),
    .i_rq_addr (RF_Rq_addr),
    .o_rp_data (w_rp_data),
    .o_rq_data (w_rq_data)
  );

  assign w_alu_op = alu_op_t'({alu_s1, alu_s0});
  assign w_wb_sel = rf_sel_t'({RF_s1, RF_s0});

  // ALU: modulo 2^DATA_W, carries and borrows are discarded.
  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_PASS: w_alu_res = w_rp_data;
      ALU_ADD:  w_alu_res = w_rp_data + w_rq_data;
      ALU_SUB:  w_alu_res = w_rp_data - w_rq_data;
      default:  w_alu_res = '0;
    endcase
  end

  // Memory read path returns the pre-write contents when D_wr is also high.
  assign w_mem_rd = D_rd ? r_dmem[D_addr] : '0;

  // Write-back source; the unused 2'b11 code writes zero.
  always_comb begin
    w_wb_data = '0;
    case (w_wb_sel)
      SEL_ALU:   w_wb_data = w_alu_res;
      SEL_MEM:   w_wb_data = w_mem_rd;
      SEL_CONST: w_wb_data = RF_W_data;
      default:   w_wb_data = '0;
    endcase
  end

  // Memory is never cleared; only the write is gated off while reset is high.
  always_ff @(posedge clk) begin
    if (D_wr && !reset) begin
      r_dmem[D_addr] <= w_rp_data;
    end
  end

  assign RF_Rp_zero = RF_Rp_rd & (w_rp_data == '0);
  assign Rp_data    = w_rp_data;
  assign Rq_data    = w_rq_data;

endmodule

// File: tb/tb_bloco_operacional.sv
module tb_bloco_operacional;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] D_addr;
  logic       D_rd, D_wr;
  logic [7:0] RF_W_data;
  logic       RF_s0, RF_s1;
  logic [3:0] RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic       RF_W_wr, RF_Rp_rd, RF_Rq_rd;
  logic       alu_s0, alu_s1;
  logic       RF_Rp_zero;
  logic [7:0] Rp_data, Rq_data;

  int errors = 0;
  int checks = 0;

  bloco_operacional dut (
    .clk        (clk),
    .reset      (reset),
    .D_addr     (D_addr),
    .D_rd       (D_rd),
    .D_wr       (D_wr),
    .RF_W_data  (RF_W_data),
    .RF_s0      (RF_s0),
    .RF_s1      (RF_s1),
    .RF_W_addr  (RF_W_addr),
    .RF_Rp_addr (RF_Rp_addr),
    .RF_Rq_addr (RF_Rq_addr),
    .RF_W_wr    (RF_W_wr),
    .RF_Rp_rd   (RF_Rp_rd),
    .RF_Rq_rd   (RF_Rq_rd),
    .alu_s0     (alu_s0),
    .alu_s1     (alu_s1),
    .RF_Rp_zero (RF_Rp_zero),
    .Rp_data    (Rp_data),
    .Rq_data    (Rq_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rp_a;  logic rp_rd;
    logic [3:0] rq_a;  logic rq_rd;
    logic [1:0] alu;   logic [1:0] sel;
    logic [3:0] w_a;   logic w_wr;  logic [7:0] wdata;
    logic [7:0] d_a;   logic d_rd;  logic d_wr;
    logic [7:0] exp_rp; logic [7:0] exp_rq; logic exp_z;
  } vec_t;

  vec_t vecs[19];

  // reference model state
  int  m_r [16];
  int  m_m [256];
  bit  m_mv [256];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    RF_Rp_addr = v.rp_a; RF_Rp_rd = v.rp_rd;
    RF_Rq_addr = v.rq_a; RF_Rq_rd = v.rq_rd;
    {alu_s1, alu_s0} = v.alu; {RF_s1, RF_s0} = v.sel;
    RF_W_addr = v.w_a; RF_W_wr = v.w_wr; RF_W_data = v.wdata;
    D_addr = v.d_a; D_rd = v.d_rd; D_wr = v.d_wr;
  endtask

  function automatic vec_t mk(input int rp_a, rp_rd, rq_a, rq_rd, alu, sel, w_a, w_wr, wdata,
                              d_a, d_rd, d_wr, exp_rp, exp_rq, exp_z);
    vec_t v;
    v.rp_a = 4'(rp_a); v.rp_rd = 1'(rp_rd); v.rq_a = 4'(rq_a); v.rq_rd = 1'(rq_rd);
    v.alu = 2'(alu); v.sel = 2'(sel); v.w_a = 4'(w_a); v.w_wr = 1'(w_wr); v.wdata = 8'(wdata);
    v.d_a = 8'(d_a); v.d_rd = 1'(d_rd); v.d_wr = 1'(d_wr);
    v.exp_rp = 8'(exp_rp); v.exp_rq = 8'(exp_rq); v.exp_z = 1'(exp_z);
    return v;
  endfunction

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return a;
      1: return (a + b) % 256;
      2: return (a - b + 256) % 256;
      default: return 0;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    //                rp rd rq rd alu sel w wr wdata  d   drd dwr  exp_rp rq  z
    vecs[0]  = mk(3, 1, 0, 0, 0, 2, 3, 1, 8'h2A, 0,     0, 0, 8'h00, 0,     1); // MOVC R3, old value seen
    vecs[1]  = mk(3, 1, 0, 0, 0, 2, 1, 1, 8'hFF, 0,     0, 0, 8'h2A, 0,     0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 2, 2, 1, 8'h01, 0,     0, 0, 8'hFF, 0,     0);
    vecs[3]  = mk(1, 1, 2, 1, 1, 0, 4, 1, 0,     0,     0, 0, 8'hFF, 8'h01, 0); // R4 = FF+01
    vecs[4]  = mk(4, 1, 0, 0, 0, 0, 0, 0, 0,     0,     0, 0, 8'h00, 0,     1); // wrapped to zero
    vecs[5]  = mk(2, 1, 1, 1, 2, 0, 5, 1, 0,     0,     0, 0, 8'h01, 8'hFF, 0); // R5 = 01-FF
    vecs[6]  = mk(5, 1, 0, 0, 0, 0, 0, 0, 0,     0,     0, 0, 8'h02, 0,     0);
    vecs[7]  = mk(3, 1, 0, 0, 0, 0, 0, 0, 0,     8'h80, 0, 1, 8'h2A, 0,     0); // M[80] = R3
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 7, 1, 0,     8'h80, 1, 0, 8'h00, 0,     0); // R7 = M[80]
    vecs[9]  = mk(7, 1, 0, 0, 0, 2, 8, 1, 8'h55, 0,     0, 0, 8'h2A, 0,     0);
    vecs[10] = mk(8, 1, 0, 0, 0, 1, 8, 1, 0,     8'h81, 0, 0, 8'h55, 0,     0); // D_rd=0 -> 0
    vecs[11] = mk(8, 1, 7, 1, 0, 0, 0, 0, 0,     0,     0, 0, 8'h00, 8'h2A, 1);
    vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0,     8'h82, 0, 1, 8'hFF, 0,     0); // M[82] = FF
    vecs[13] = mk(5, 1, 0, 0, 0, 1, 9, 1, 0,     8'h82, 1, 1, 8'h02, 0,     0); // rd+wr same addr
    vecs[14] = mk(9, 1, 9, 1, 0, 0, 0, 0, 0,     0,     0, 0, 8'hFF, 8'hFF, 0); // old value, same addr
    vecs[15] = mk(3, 1, 0, 0, 0, 1, 10, 1, 0,    8'h82, 1, 0, 8'h2A, 0,     0);
    vecs[16] = mk(10, 1, 0, 0, 0, 0, 11, 1, 0,   0,     0, 0, 8'h02, 0,     0); // PASS -> R11
    vecs[17] = mk(11, 1, 0, 0, 3, 3, 11, 1, 0,   0,     0, 0, 8'h02, 0,     0); // sel 11 -> 0
    vecs[18] = mk(11, 1, 4, 0, 0, 0, 0, 0, 0,    0,     0, 0, 8'h00, 0,     1);
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(idle);
    reset = 1'b1;
    #13 reset = 1'b0;

    // every register reads zero after reset, on both ports
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1;
      RF_Rp_addr = 4'(r); RF_Rp_rd = 1'b1;
      RF_Rq_addr = 4'(15 - r); RF_Rq_rd = 1'b1;
      @(negedge clk);
      check("reset_rp", Rp_data, 8'h00);
      check("reset_rq", Rq_data, 8'h00);
      check("reset_zero_en", {7'b0, RF_Rp_zero}, 8'h01);
    end
    @(posedge clk); #1;
    RF_Rp_rd = 1'b0;
    @(negedge clk);
    check("reset_zero_dis", {7'b0, RF_Rp_zero}, 8'h00);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_rp", i), Rp_data, vecs[i].exp_rp);
      check($sformatf("vec%0d_rq", i), Rq_data, vecs[i].exp_rq);
      check($sformatf("vec%0d_z", i), {7'b0, RF_Rp_zero}, {7'b0, vecs[i].exp_z});
    end

    // async reset between edges while a write to R3 is pending
    @(posedge clk); #1;
    drive(mk(3, 1, 0, 0, 0, 2, 3, 1, 8'h77, 0, 0, 0, 0, 0, 0));
    #1 check("pre_reset_r3", Rp_data, 8'h2A);
    #1 reset = 1'b1;
    #1 check("async_clear_r3", Rp_data, 8'h00);
    check("async_clear_z", {7'b0, RF_Rp_zero}, 8'h01);
    @(posedge clk); #1;
    check("no_write_in_reset", Rp_data, 8'h00);
    #2 reset = 1'b0;
    drive(idle);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 1, 6, 1, 0, 8'h80, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(6, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("mem_kept_after_reset", Rp_data, 8'h2A);
    check("r3_after_reset", Rq_data, 8'h00);

    // randomized run against the reference model, starting from a fresh reset
    @(posedge clk); #1;
    drive(idle);
    reset = 1'b1;
    #3 reset = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    for (int i = 0; i < 256; i++) m_mv[i] = 1'b0;

    for (int n = 0; n < 400; n++) begin
      int a, b, op, sel, memv, wb, da;
      vec_t v;
      v = idle;
      v.rp_a = 4'($urandom_range(0, 15)); v.rp_rd = 1'($urandom_range(0, 3) != 0);
      v.rq_a = 4'($urandom_range(0, 15)); v.rq_rd = 1'($urandom_range(0, 3) != 0);
      v.alu  = 2'($urandom_range(0, 3));
      v.sel  = 2'($urandom_range(0, 3));
      v.w_a  = 4'($urandom_range(0, 15)); v.w_wr = 1'($urandom_range(0, 1));
      v.wdata = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) v.wdata = 8'h00;
      da = $urandom_range(0, 15);
      v.d_a  = 8'(da);
      v.d_wr = 1'($urandom_range(0, 2) == 0);
      v.d_rd = 1'($urandom_range(0, 1)) & m_mv[da];
      @(posedge clk); #1;
      drive(v);

      a = v.rp_rd ? m_r[v.rp_a] : 0;
      b = v.rq_rd ? m_r[v.rq_a] : 0;
      op = int'(v.alu);
      sel = int'(v.sel);
      memv = v.d_rd ? m_m[da] : 0;
      case (sel)
        0: wb = ref_alu(op, a, b);
        1: wb = memv;
        2: wb = int'(v.wdata);
        default: wb = 0;
      endcase

      @(negedge clk);
      check("rand_rp", Rp_data, 8'(a));
      check("rand_rq", Rq_data, 8'(b));
      check("rand_zero", {7'b0, RF_Rp_zero}, {7'b0, (v.rp_rd && a == 0)});

      if (v.w_wr) m_r[v.w_a] = wb;
      if (v.d_wr) begin
        m_m[da] = a;
        m_mv[da] = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
